// File: rtl/hmmm_mem_loader_if.sv
// Bundles the processor data port and the byte-stream loader port of hmmm_mem_loader.
// The slave side is the loader/memory block; the master side is the CPU plus the image source.
interface hmmm_mem_loader_if;
    logic        MemWrite;
    logic [7:0]  adr;
    logic [7:0]  WriteData;
    logic [14:0] ReadData;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [8:0]  load_count;

    modport slave (
        input  MemWrite, adr, WriteData, ld_valid, ld_data, ld_last,
        output ReadData, ld_ready, cpu_reset, load_done, load_err, load_count
    );

    modport master (
        output MemWrite, adr, WriteData, ld_valid, ld_data, ld_last,
        input  ReadData, ld_ready, cpu_reset, load_done, load_err, load_count
    );
endinterface

// File: rtl/hmmm_mem_loader.sv
// Program memory that is first filled from a big-endian byte stream (7-bit high byte, 8-bit low
// byte per 15-bit word), then released to the processor as an asynchronously read data/fetch memory.
module hmmm_mem_loader #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    hmmm_mem_loader_if.slave  bus
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam logic [8:0]  DEPTH = 9'(MEM_WORDS);

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  hi_q, hi_d;
    logic [8:0]  count_q, count_d;
    logic        ready_q, ready_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [14:0] mem_q [MEM_WORDS];

    logic          xfer_s;
    logic          adr_ok_s;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [14:0]   wdata_s;

    // ready_q is high exactly in the two load states, so it doubles as the handshake qualifier
    assign xfer_s   = bus.ld_valid & ready_q;
    assign adr_ok_s = ({1'b0, bus.adr} < DEPTH);

    // Next-state, word assembly and the single memory write port
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        count_d = count_q;
        we_s    = 1'b0;
        waddr_s = '0;
        wdata_s = 15'd0;
        case (state_q)
            LOAD_HI: begin
                if (xfer_s) begin
                    if (bus.ld_data[7] || bus.ld_last || (count_q == DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        hi_d    = bus.ld_data[6:0];
                        state_d = LOAD_LO;
                    end
                end else begin
                    state_d = LOAD_HI;
                end
            end
            LOAD_LO: begin
                if (xfer_s) begin
                    we_s    = 1'b1;
                    waddr_s = count_q[AW-1:0];
                    wdata_s = {hi_q, bus.ld_data};
                    count_d = count_q + 9'd1;
                    state_d = bus.ld_last ? RUN : LOAD_HI;
                end else begin
                    state_d = LOAD_LO;
                end
            end
            RUN: begin
                if (bus.MemWrite && adr_ok_s) begin
                    we_s    = 1'b1;
                    waddr_s = bus.adr[AW-1:0];
                    wdata_s = {7'd0, bus.WriteData};
                end else begin
                    we_s    = 1'b0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    // Status flags are decoded from the next state so they can be registered without lag
    always_comb begin
        ready_d   = 1'b0;
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            LOAD_HI: begin
                ready_d = 1'b1;
            end
            LOAD_LO: begin
                ready_d = 1'b1;
            end
            RUN: begin
                cpu_rst_d = 1'b0;
                done_d    = 1'b1;
            end
            ERR: begin
                err_d = 1'b1;
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOAD_HI;
            hi_q      <= 7'd0;
            count_q   <= 9'd0;
            ready_q   <= 1'b1;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Array storage keeps its contents through reset so a reload only overwrites what it touches
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    assign bus.ReadData   = ((state_q == RUN) && adr_ok_s) ? mem_q[bus.adr[AW-1:0]] : 15'd0;
    assign bus.ld_ready   = ready_q;
    assign bus.cpu_reset  = cpu_rst_q;
    assign bus.load_done  = done_q;
    assign bus.load_err   = err_q;
    assign bus.load_count = count_q;

endmodule

// File: tb/tb_hmmm_mem_loader.sv
// Self-checking bench for hmmm_mem_loader: a vector table for the basic load/run flow, directed
// corner sequences, and random byte streams checked against a stream-level image model.
module tb_hmmm_mem_loader;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    hmmm_mem_loader_if ifa ();
    hmmm_mem_loader_if ifb ();

    hmmm_mem_loader #(.MEM_WORDS(256)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    hmmm_mem_loader #(.MEM_WORDS(4))   dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        mw;
        logic [7:0]  adr;
        logic [7:0]  wd;
        logic [14:0] rd;
        logic        rdy;
        logic        cr;
        logic        done;
        logic        err;
        logic [8:0]  cnt;
    } vec_t;

    vec_t        tbl [8];
    logic [7:0]  qb [$];
    bit          ql [$];
    logic [14:0] mm [256];
    int          m_cnt;
    int          m_st;
    logic [7:0]  hb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic rdy, input logic cr, input logic done,
                         input logic err, input logic [8:0] cnt);
        chk({tag, "_rdy"},  32'(ifa.ld_ready),   32'(rdy));
        chk({tag, "_cr"},   32'(ifa.cpu_reset),  32'(cr));
        chk({tag, "_done"}, 32'(ifa.load_done),  32'(done));
        chk({tag, "_err"},  32'(ifa.load_err),   32'(err));
        chk({tag, "_cnt"},  32'(ifa.load_count), 32'(cnt));
    endtask

    task automatic chk_b(input string tag, input logic rdy, input logic cr, input logic done,
                         input logic err, input logic [8:0] cnt);
        chk({tag, "_rdy"},  32'(ifb.ld_ready),   32'(rdy));
        chk({tag, "_cr"},   32'(ifb.cpu_reset),  32'(cr));
        chk({tag, "_done"}, 32'(ifb.load_done),  32'(done));
        chk({tag, "_err"},  32'(ifb.load_err),   32'(err));
        chk({tag, "_cnt"},  32'(ifb.load_count), 32'(cnt));
    endtask

    task automatic idle_all();
        ifa.ld_valid = 1'b0; ifa.ld_data = 8'h00; ifa.ld_last = 1'b0;
        ifa.MemWrite = 1'b0; ifa.adr = 8'h00; ifa.WriteData = 8'h00;
        ifb.ld_valid = 1'b0; ifb.ld_data = 8'h00; ifb.ld_last = 1'b0;
        ifb.MemWrite = 1'b0; ifb.adr = 8'h00; ifb.WriteData = 8'h00;
    endtask

    // all tasks below start and end just after a falling edge
    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic last);
        ifa.ld_valid = 1'b1; ifa.ld_data = d; ifa.ld_last = last;
        @(negedge clk);
        ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        ifb.ld_valid = 1'b1; ifb.ld_data = d; ifb.ld_last = last;
        @(negedge clk);
        ifb.ld_valid = 1'b0; ifb.ld_last = 1'b0;
    endtask

    task automatic read_a(input string nm, input logic [7:0] a, input logic [14:0] exp);
        ifa.adr = a;
        #1 chk(nm, 32'(ifa.ReadData), 32'(exp));
    endtask

    task automatic read_b(input string nm, input logic [7:0] a, input logic [14:0] exp);
        ifb.adr = a;
        #1 chk(nm, 32'(ifb.ReadData), 32'(exp));
    endtask

    // feed the current stream, optionally with random idle cycles carrying junk data/last
    task automatic drive_stream(input bit gaps);
        int  k;
        int  cyc;
        logic v;
        k = 0;
        cyc = 0;
        while (k < qb.size() && cyc < 1000) begin
            if (!ifa.ld_ready) break;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ifa.ld_valid = v;
            ifa.ld_data  = v ? qb[k] : 8'($urandom);
            ifa.ld_last  = v ? ql[k] : 1'($urandom);
            @(negedge clk);
            cyc++;
            if (v) k++;
        end
        idle_all();
        chk("stream_budget", 32'(cyc < 1000), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk_a(tag, m_st == 0, m_st != 1, m_st == 1, m_st == 2, 9'(m_cnt));
        if (m_st == 1) begin
            for (int i = 0; i < m_cnt; i++) read_a({tag, "_word"}, 8'(i), mm[i]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_all();

        tbl[0] = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h00, 8'hEE, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[1] = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[2] = '{1'b1, 8'h34, 1'b0, 1'b1, 8'h01, 8'hEE, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd1};
        tbl[3] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd1};
        tbl[4] = '{1'b1, 8'h56, 1'b1, 1'b0, 8'h00, 8'h00, 15'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};
        tbl[5] = '{1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 8'h00, 15'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'hAB, 15'h0056, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 15'h00AB, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};

        // held in reset across clock edges
        repeat (3) @(negedge clk);
        chk_a("rst_a", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        chk_b("rst_b", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        chk("rst_rd_a", 32'(ifa.ReadData), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic image load, same-cycle read and write-then-read
        for (int i = 0; i < 8; i++) begin
            ifa.ld_valid = tbl[i].v;  ifa.ld_data = tbl[i].d;   ifa.ld_last = tbl[i].l;
            ifa.MemWrite = tbl[i].mw; ifa.adr     = tbl[i].adr; ifa.WriteData = tbl[i].wd;
            #1 chk($sformatf("tbl%0d_rd", i), 32'(ifa.ReadData), 32'(tbl[i].rd));
            @(negedge clk);
            chk_a($sformatf("tbl%0d", i), tbl[i].rdy, tbl[i].cr, tbl[i].done, tbl[i].err, tbl[i].cnt);
        end
        idle_all();

        // asynchronous reset from RUN, then held over an edge with a valid byte present
        #2 reset = 1'b1;
        #1 chk_a("async", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        chk("async_rd", 32'(ifa.ReadData), 32'd0);
        ifa.ld_valid = 1'b1; ifa.ld_data = 8'h12;
        @(negedge clk);
        chk_a("rst_hold", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        idle_all();
        reset = 1'b0;
        @(negedge clk);

        // processor stores during loading are dropped and reads return 0
        ifa.MemWrite = 1'b1; ifa.adr = 8'h01; ifa.WriteData = 8'h55;
        send_a(8'h7F, 1'b0);
        #1 chk("ld_rd_zero", 32'(ifa.ReadData), 32'd0);
        send_a(8'hFF, 1'b1);
        ifa.MemWrite = 1'b0;
        chk_a("mwload", 1'b0, 1'b0, 1'b1, 1'b0, 9'd1);
        read_a("mwload_w0", 8'h00, 15'h7FFF);
        read_a("mwload_w1", 8'h01, 15'h00AB);

        // reset between high and low byte discards the held byte
        @(negedge clk);
        do_reset();
        send_a(8'h01, 1'b0);
        #2 reset = 1'b1;
        #1 chk_a("midrst", 1'b1, 1'b1, 1'b0, 1'b0, 9'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_a(8'h04, 1'b0);
        send_a(8'h05, 1'b1);
        chk_a("reload", 1'b0, 1'b0, 1'b1, 1'b0, 9'd1);
        read_a("reload_w0", 8'h00, 15'h0405);
        read_a("reload_w1", 8'h01, 15'h00AB);

        // high byte with bit 7 set
        @(negedge clk);
        do_reset();
        send_a(8'h80, 1'b0);
        chk_a("bit7", 1'b0, 1'b1, 1'b0, 1'b1, 9'd0);
        ifa.MemWrite = 1'b1; ifa.adr = 8'h00; ifa.WriteData = 8'h11;
        send_a(8'h12, 1'b0);
        chk_a("err_stuck", 1'b0, 1'b1, 1'b0, 1'b1, 9'd0);
        #1 chk("err_rd", 32'(ifa.ReadData), 32'd0);

        // last flag on a high byte writes nothing
        @(negedge clk);
        do_reset();
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        send_a(8'h33, 1'b1);
        chk_a("hilast", 1'b0, 1'b1, 1'b0, 1'b1, 9'd1);
        do_reset();
        send_a(8'h44, 1'b0);
        send_a(8'h55, 1'b1);
        chk_a("hilast_rl", 1'b0, 1'b0, 1'b1, 1'b0, 9'd1);
        read_a("hilast_w0", 8'h00, 15'h4455);
        read_a("hilast_w1", 8'h01, 15'h00AB);
        @(negedge clk);

        // random streams, each loaded gap-free and then with random gaps
        for (int r = 0; r < 6; r++) begin
            int nw;
            qb.delete();
            ql.delete();
            nw = $urandom_range(1, 10);
            for (int w = 0; w < nw; w++) begin
                hb = 8'($urandom_range(0, 127));
                if ($urandom_range(0, 11) == 0) hb[7] = 1'b1;
                qb.push_back(hb);
                ql.push_back($urandom_range(0, 15) == 0);
                qb.push_back(8'($urandom));
                ql.push_back((w == nw - 1) && ($urandom_range(0, 3) != 0));
            end
            // image model: even positions are high bytes, odd positions complete a word
            m_cnt = 0;
            m_st  = 0;
            for (int k = 0; k < qb.size(); k++) begin
                if (k % 2 == 0) begin
                    if (m_cnt == 256 || qb[k][7] || ql[k]) begin
                        m_st = 2;
                        break;
                    end
                end else begin
                    mm[m_cnt] = {qb[k-1][6:0], qb[k]};
                    m_cnt++;
                    if (ql[k]) begin
                        m_st = 1;
                        break;
                    end
                end
            end
            do_reset();
            drive_stream(1'b0);
            check_stream($sformatf("rnd%0d_flat", r));
            @(negedge clk);
            do_reset();
            drive_stream(1'b1);
            check_stream($sformatf("rnd%0d_gap", r));
            @(negedge clk);
        end

        // four-word array: a fifth word overflows on its high byte
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send_b(8'(i), 1'b0);
            send_b(8'(i * 16), 1'b0);
        end
        chk_b("ovf_full", 1'b1, 1'b1, 1'b0, 1'b0, 9'd4);
        send_b(8'h05, 1'b0);
        chk_b("ovf", 1'b0, 1'b1, 1'b0, 1'b1, 9'd4);

        // four-word array run: out-of-range reads and stores
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send_b(8'(i), 1'b0);
            send_b(8'(i * 16), i == 4);
        end
        chk_b("b_run", 1'b0, 1'b0, 1'b1, 1'b0, 9'd4);
        read_b("b_w3", 8'h03, 15'h0440);
        read_b("b_oor4", 8'h04, 15'h0000);
        read_b("b_oor255", 8'hFF, 15'h0000);
        @(negedge clk);
        ifb.MemWrite = 1'b1; ifb.adr = 8'h04; ifb.WriteData = 8'hCC;
        @(negedge clk);
        ifb.adr = 8'h03; ifb.WriteData = 8'h3C;
        @(negedge clk);
        ifb.MemWrite = 1'b0;
        read_b("b_alias_w0", 8'h00, 15'h0110);
        read_b("b_w3_new", 8'h03, 15'h003C);
        read_b("b_oor_after", 8'h04, 15'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
